// File: rtl/alarm_bank.sv
// alarm_bank: multi-slot hh:mm:ss alarm unit with a single ringer FSM (timeout, stop, snooze).
// Define ALARM_BANK_SNOOZE_EN to build the SNOOZE state; otherwise snooze is ignored.
module alarm_bank #(
   parameter int NUM_ALARMS     = 4,
   parameter int RING_SECONDS   = 60,
   parameter int SNOOZE_MINUTES = 5,
   parameter int SW             = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tick_1hz,
   input  logic [5:0]            sec_in,
   input  logic [5:0]            min_in,
   input  logic [4:0]            hour_in,
   input  logic [SW-1:0]         slot_sel,
   input  logic [1:0]            field_sel,
   input  logic                  increment,
   input  logic                  decrement,
   input  logic                  toggle_en,
   input  logic                  stop,
   input  logic                  snooze,
   output logic [5:0]            sec_out,
   output logic [5:0]            min_out,
   output logic [4:0]            hour_out,
   output logic [NUM_ALARMS-1:0] en_mask,
   output logic                  ringing,
   output logic [SW-1:0]         ring_id,
   output logic                  snoozing
);
   localparam int RW = (RING_SECONDS > 1) ? $clog2(RING_SECONDS) : 1;
`ifdef ALARM_BANK_SNOOZE_EN
   localparam int ST  = SNOOZE_MINUTES * 60;
   localparam int SNW = (ST > 1) ? $clog2(ST) : 1;
   localparam int CW  = (RW > SNW) ? RW : SNW;
`else
   localparam int CW = RW;
   localparam int unused_snooze_minutes = SNOOZE_MINUTES;
   logic unused_snooze;
   assign unused_snooze = snooze;
`endif

   typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;

   logic [5:0]            sec_q  [NUM_ALARMS];
   logic [5:0]            sec_d  [NUM_ALARMS];
   logic [5:0]            min_q  [NUM_ALARMS];
   logic [5:0]            min_d  [NUM_ALARMS];
   logic [4:0]            hour_q [NUM_ALARMS];
   logic [4:0]            hour_d [NUM_ALARMS];
   logic [NUM_ALARMS-1:0] en_q, en_d;
   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [SW-1:0]         id_q, id_d, win;
   logic                  hit, step_en;

   function automatic logic [5:0] wrap60(input logic [5:0] v, input logic up);
      return up ? ((v == 6'd59) ? 6'd0 : v + 6'd1) : ((v == 6'd0) ? 6'd59 : v - 6'd1);
   endfunction

   function automatic logic [4:0] wrap24(input logic [4:0] v, input logic up);
      return up ? ((v == 5'd23) ? 5'd0 : v + 5'd1) : ((v == 5'd0) ? 5'd23 : v - 5'd1);
   endfunction

   assign step_en = increment ^ decrement;

   // Out-of-range slot_sel never equals a loop index, so it reads 0 and edits nothing.
   always_comb begin
      sec_d    = sec_q;
      min_d    = min_q;
      hour_d   = hour_q;
      en_d     = en_q;
      sec_out  = '0;
      min_out  = '0;
      hour_out = '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
         if (int'(slot_sel) == i) begin
            sec_out  = sec_q[i];
            min_out  = min_q[i];
            hour_out = hour_q[i];
            if (step_en && field_sel == 2'd0) sec_d[i] = wrap60(sec_q[i], increment);
            if (step_en && field_sel == 2'd1) min_d[i] = wrap60(min_q[i], increment);
            if (step_en && field_sel == 2'd2) hour_d[i] = wrap24(hour_q[i], increment);
            if (toggle_en) en_d[i] = ~en_q[i];
         end
      end
   end

   // Scan downward so the lowest matching index is left in win.
   always_comb begin
      hit = 1'b0;
      win = '0;
      for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
         if (en_q[i] && sec_q[i] == sec_in && min_q[i] == min_in && hour_q[i] == hour_in) begin
            hit = 1'b1;
            win = SW'(i);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      id_d    = id_q;
      case (state_q)
         IDLE: begin
            if (tick_1hz && hit) begin
               state_d = RINGING;
               cnt_d   = '0;
               id_d    = win;
            end
         end
         RINGING: begin
            if (stop) state_d = IDLE;
`ifdef ALARM_BANK_SNOOZE_EN
            else if (snooze) begin
               state_d = SNOOZE;
               cnt_d   = '0;
            end
`endif
            else if (tick_1hz) begin
               if (cnt_q == CW'(RING_SECONDS - 1)) state_d = IDLE;
               else cnt_d = cnt_q + 1'b1;
            end
         end
`ifdef ALARM_BANK_SNOOZE_EN
         SNOOZE: begin
            if (stop) state_d = IDLE;
            else if (tick_1hz) begin
               if (cnt_q == CW'(ST - 1)) begin
                  state_d = RINGING;
                  cnt_d   = '0;
               end else cnt_d = cnt_q + 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sec_q   <= '{default: '0};
         min_q   <= '{default: '0};
         hour_q  <= '{default: '0};
         en_q    <= '0;
         state_q <= IDLE;
         cnt_q   <= '0;
         id_q    <= '0;
      end else begin
         sec_q   <= sec_d;
         min_q   <= min_d;
         hour_q  <= hour_d;
         en_q    <= en_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         id_q    <= id_d;
      end
   end

   assign en_mask = en_q;
   assign ringing = state_q == RINGING;
   assign ring_id = id_q;
`ifdef ALARM_BANK_SNOOZE_EN
   assign snoozing = state_q == SNOOZE;
`else
   assign snoozing = 1'b0;
`endif
endmodule

// File: tb/tb_alarm_bank.sv
// tb_alarm_bank: directed vectors for alarm_bank with five slots so slot_sel=5 is out of range.
module tb_alarm_bank;
   localparam int NA = 5;
   localparam int SW = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          tick_1hz = 1'b0;
   logic [5:0]    sec_in = '0;
   logic [5:0]    min_in = '0;
   logic [4:0]    hour_in = '0;
   logic [SW-1:0] slot_sel = '0;
   logic [1:0]    field_sel = 2'd3;
   logic          increment = 1'b0;
   logic          decrement = 1'b0;
   logic          toggle_en = 1'b0;
   logic          stop = 1'b0;
   logic          snooze = 1'b0;
   logic [5:0]    sec_out;
   logic [5:0]    min_out;
   logic [4:0]    hour_out;
   logic [NA-1:0] en_mask;
   logic          ringing;
   logic [SW-1:0] ring_id;
   logic          snoozing;
   int            n_vec = 0;
   int            n_bad = 0;

   alarm_bank #(.NUM_ALARMS(NA), .RING_SECONDS(60), .SNOOZE_MINUTES(5)) dut (
      .clk(clk), .reset(reset), .tick_1hz(tick_1hz),
      .sec_in(sec_in), .min_in(min_in), .hour_in(hour_in),
      .slot_sel(slot_sel), .field_sel(field_sel),
      .increment(increment), .decrement(decrement), .toggle_en(toggle_en),
      .stop(stop), .snooze(snooze),
      .sec_out(sec_out), .min_out(min_out), .hour_out(hour_out),
      .en_mask(en_mask), .ringing(ringing), .ring_id(ring_id), .snoozing(snoozing)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic edit(input logic [SW-1:0] s, input logic [1:0] f, input logic inc, input logic dec,
                       input logic tog, input int n);
      slot_sel  = s;
      field_sel = f;
      repeat (n) begin
         increment = inc;
         decrement = dec;
         toggle_en = tog;
         step();
      end
      increment = 1'b0;
      decrement = 1'b0;
      toggle_en = 1'b0;
   endtask

   task automatic look(input logic [SW-1:0] s);
      slot_sel = s;
      #1;
   endtask

   task automatic tick_at(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
      hour_in  = h;
      min_in   = m;
      sec_in   = s;
      tick_1hz = 1'b1;
      step();
      tick_1hz = 1'b0;
   endtask

   task automatic fill(input int n);
      repeat (n) tick_at(5'd1, 6'd1, 6'd1);
   endtask

   task automatic ctl(input logic st, input logic sn);
      stop   = st;
      snooze = sn;
      step();
      stop   = 1'b0;
      snooze = 1'b0;
   endtask

   initial begin
      repeat (3) step();
      chk("rst_hour", hour_out, 0);
      chk("rst_en", en_mask, 0);
      chk("rst_ring", ringing, 0);
      chk("rst_snz", snoozing, 0);
      chk("rst_id", ring_id, 0);
      reset = 1'b0;
      step();

      edit(3'd2, 2'd2, 1, 0, 0, 25);
      look(3'd2);
      chk("hour_25inc", hour_out, 1);
      edit(3'd2, 2'd0, 0, 1, 0, 1);
      look(3'd2);
      chk("sec_dec_wrap", sec_out, 59);
      edit(3'd2, 2'd0, 1, 1, 0, 1);
      look(3'd2);
      chk("inc_dec_same", sec_out, 59);
      edit(3'd2, 2'd0, 1, 0, 0, 1);
      look(3'd2);
      chk("sec_inc_wrap", sec_out, 0);
      edit(3'd2, 2'd2, 0, 1, 0, 2);
      look(3'd2);
      chk("hour_dec_wrap", hour_out, 23);
      edit(3'd2, 2'd2, 1, 0, 0, 1);
      look(3'd2);
      chk("hour_inc_wrap", hour_out, 0);
      edit(3'd2, 2'd1, 0, 1, 0, 1);
      look(3'd2);
      chk("min_dec_wrap", min_out, 59);
      edit(3'd2, 2'd1, 1, 0, 0, 1);
      edit(3'd2, 2'd3, 1, 0, 1, 1);
      look(3'd2);
      chk("fsel3_min", min_out, 0);
      chk("fsel3_hour", hour_out, 0);
      chk("fsel3_toggle", en_mask, 5'b00100);
      edit(3'd2, 2'd3, 0, 0, 1, 1);
      look(3'd0);
      chk("slot0_sec", sec_out, 0);
      chk("slot0_hour", hour_out, 0);
      look(3'd1);
      chk("slot1_hour", hour_out, 0);
      look(3'd3);
      chk("slot3_sec", sec_out, 0);

      edit(3'd5, 2'd2, 1, 0, 1, 3);
      look(3'd5);
      chk("oor_hour", hour_out, 0);
      chk("oor_en", en_mask, 0);
      look(3'd4);
      chk("slot4_hour", hour_out, 0);

      edit(3'd1, 2'd2, 1, 0, 0, 7);
      edit(3'd1, 2'd1, 1, 0, 0, 30);
      edit(3'd1, 2'd3, 0, 0, 1, 1);
      look(3'd1);
      chk("s1_hour", hour_out, 7);
      chk("s1_min", min_out, 30);
      chk("s1_en", en_mask, 5'b00010);
      tick_at(5'd7, 6'd29, 6'd59);
      chk("pre_match", ringing, 0);
      hour_in = 5'd7;
      min_in  = 6'd30;
      sec_in  = 6'd0;
      step();
      step();
      chk("match_no_tick", ringing, 0);
      tick_at(5'd7, 6'd30, 6'd0);
      chk("ring_rise", ringing, 1);
      chk("ring_id1", ring_id, 1);
      fill(59);
      chk("ring_59", ringing, 1);
      fill(1);
      chk("ring_timeout", ringing, 0);

      edit(3'd0, 2'd2, 1, 0, 0, 12);
      edit(3'd0, 2'd3, 0, 0, 1, 1);
      edit(3'd3, 2'd2, 1, 0, 0, 12);
      edit(3'd3, 2'd3, 0, 0, 1, 1);
      chk("prio_en", en_mask, 5'b01011);
      tick_at(5'd12, 6'd0, 6'd0);
      chk("prio_ring", ringing, 1);
      chk("prio_id0", ring_id, 0);
      ctl(1, 0);
      chk("stop", ringing, 0);
      edit(3'd0, 2'd3, 0, 0, 1, 1);
      tick_at(5'd12, 6'd0, 6'd0);
      chk("prio_id3", ring_id, 3);
      ctl(1, 0);
      edit(3'd3, 2'd3, 0, 0, 1, 1);
      tick_at(5'd12, 6'd0, 6'd0);
      chk("both_off", ringing, 0);
      ctl(0, 1);
      chk("idle_snooze", snoozing, 0);

      tick_at(5'd7, 6'd30, 6'd0);
      edit(3'd3, 2'd3, 0, 0, 1, 1);
      tick_at(5'd12, 6'd0, 6'd0);
      chk("busy_ignore_id", ring_id, 1);
      edit(3'd1, 2'd3, 0, 0, 1, 1);
      chk("disable_keeps", ringing, 1);
      ctl(1, 1);
      chk("stop_wins_ring", ringing, 0);
      chk("stop_wins_snz", snoozing, 0);

      tick_at(5'd12, 6'd0, 6'd0);
      chk("ring3", ring_id, 3);
      ctl(0, 1);
`ifdef ALARM_BANK_SNOOZE_EN
      chk("snz_enter", snoozing, 1);
      chk("snz_quiet", ringing, 0);
      fill(299);
      chk("snz_299", snoozing, 1);
      fill(1);
      chk("snz_back", ringing, 1);
      chk("snz_id", ring_id, 3);
      chk("snz_exit", snoozing, 0);
      ctl(0, 1);
      fill(10);
      chk("snz_again", snoozing, 1);
`else
      chk("nosnz_ring", ringing, 1);
      chk("nosnz_flag", snoozing, 0);
      fill(59);
      chk("nosnz_59", ringing, 1);
      fill(1);
      chk("nosnz_timeout", ringing, 0);
      tick_at(5'd12, 6'd0, 6'd0);
      fill(10);
`endif
      #2;
      reset = 1'b1;
      #1;
      chk("arst_ring", ringing, 0);
      chk("arst_snz", snoozing, 0);
      chk("arst_id", ring_id, 0);
      chk("arst_en", en_mask, 0);
      look(3'd1);
      chk("arst_hour", hour_out, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
